// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Accepts 32-bit instruction words over a valid/ready handshake and writes
// them big-endian, one byte per cycle, into an instruction byte store starting
// at byte address 0. A session ends when the word flagged as last is written,
// or when the store becomes full.
//
// Optional feature: define INSTRUCTION_LOADER_CHECKSUM_EN to add the 8-bit
// 'checksum' output. It is the XOR of every byte written since the last start.
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W-2:0] words_loaded
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The base address plus one word, one bit wider so the end of the store
    // (MEM_BYTES) can be compared without wrapping.
    localparam logic [ADDR_W:0]   STORE_END = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   WORD_STEP = (ADDR_W+1)'(4);
    localparam logic [ADDR_W-2:0] WORD_INC  = (ADDR_W-1)'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [1:0]          idx_q;
    logic [31:0]         word_q;
    logic                last_q;
    logic [ADDR_W-2:0]   words_q;
    logic                in_ready_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;
    logic                busy_q;
    logic                done_q;
    logic                full_q;

    logic [1:0]          next_idx_d;
    logic [ADDR_W:0]     base_plus4_d;
    logic                store_full_d;
    logic [7:0]          next_byte_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic                handshake_d;

    // Big-endian byte select: index 0 is the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next byte to present: the first byte of a freshly accepted word, or the
    // following byte of the word currently being written.
    always_comb begin
        next_idx_d   = idx_q + 2'd1;
        base_plus4_d = {1'b0, base_q} + WORD_STEP;
        store_full_d = (base_plus4_d == STORE_END);
        handshake_d  = (state_q == S_ACCEPT) && in_valid && in_ready_q;
        if (state_q == S_ACCEPT) begin
            next_byte_d = byte_sel(in_word, 2'd0);
            next_addr_d = base_q;
        end else begin
            next_byte_d = byte_sel(word_q, next_idx_d);
            next_addr_d = base_q + {{(ADDR_W-2){1'b0}}, next_idx_d};
        end
    end

    // Session FSM; every output is a register loaded alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            idx_q      <= 2'd0;
            word_q     <= 32'h0;
            last_q     <= 1'b0;
            words_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_ACCEPT;
                        base_q     <= '0;
                        words_q    <= '0;
                        full_q     <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (handshake_d) begin
                        state_q    <= S_WRITE;
                        word_q     <= in_word;
                        last_q     <= in_last;
                        idx_q      <= 2'd0;
                        in_ready_q <= 1'b0;
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= next_addr_d;
                        wr_data_q  <= next_byte_d;
                    end
                end
                S_WRITE: begin
                    if (idx_q == 2'd3) begin
                        wr_en_q <= 1'b0;
                        base_q  <= base_plus4_d[ADDR_W-1:0];
                        words_q <= words_q + WORD_INC;
                        if (last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (store_full_d) begin
                            // Never wrap: the store is full, end the session.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            full_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_ACCEPT;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        idx_q     <= next_idx_d;
                        wr_addr_q <= next_addr_d;
                        wr_data_q <= next_byte_d;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    wr_en_q    <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q;
    logic       emit_d;
    logic       restart_d;

    // A byte is presented on the edge that accepts a word and on the edges
    // that advance to bytes 1..3; the checksum folds in exactly those bytes.
    always_comb begin
        emit_d    = handshake_d || ((state_q == S_WRITE) && (idx_q != 2'd3));
        restart_d = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    end

    // Running XOR of the written bytes, cleared at every session start.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= 8'h00;
        end else if (restart_d) begin
            checksum_q <= 8'h00;
        end else if (emit_d) begin
            checksum_q <= checksum_q ^ next_byte_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign full         = full_q;
    assign words_loaded = words_q;

endmodule
